// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned MUL / DIVU / REMU that borrows the shared execute-stage ALU
// for every add or subtract; shift-and-add multiply, restoring divide.
module alu_muldiv_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic                  ALUsrc,
    input  logic [DATA_WIDTH-1:0] ALUout
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [1:0] OpMul  = 2'b00;
    localparam logic [1:0] OpDivu = 2'b01;
    localparam logic [1:0] OpRemu = 2'b10;
    localparam logic [1:0] OpRsvd = 2'b11;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    // The partial remainder is always below the divisor, so its extra top bit stays
    // zero and is not stored; it reappears as rn[DATA_WIDTH] after the shift.
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic [DATA_WIDTH:0]   rn;
    logic                  ge;

    assign rn = {rem_q, quo_q[DATA_WIDTH-1]};
    assign ge = rn[DATA_WIDTH] | (rn[DATA_WIDTH-1:0] >= divisor_q);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        ALUop1    = '0;
        ALUop2    = '0;
        ALUctrl   = AluAdd;

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d      = op;
                    cnt_d     = '0;
                    acc_d     = '0;
                    mcand_d   = opa;
                    mplier_d  = opb;
                    rem_d     = '0;
                    quo_d     = opa;
                    divisor_d = opb;
                    if (op == OpRsvd) begin
                        result_d = '0;
                        state_d  = StDone;
                    end else if (op != OpMul && opb == '0) begin
                        result_d = (op == OpDivu) ? '1 : opa;
                        state_d  = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end

            StCalc: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OpMul) begin
                    ALUop1  = acc_q;
                    ALUop2  = mcand_q;
                    ALUctrl = AluAdd;
                    if (mplier_q[0]) begin
                        acc_d = ALUout;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    ALUop1  = rn[DATA_WIDTH-1:0];
                    ALUop2  = divisor_q;
                    ALUctrl = AluSub;
                    // A wrapped difference is exact here since the true value is < divisor.
                    rem_d   = ge ? ALUout : rn[DATA_WIDTH-1:0];
                    quo_d   = {quo_q[DATA_WIDTH-2:0], ge};
                end

                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    case (op_q)
                        OpMul:   result_d = acc_d;
                        OpDivu:  result_d = quo_d;
                        OpRemu:  result_d = rem_d;
                        default: result_d = '0;
                    endcase
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
        end
    end

    assign ready  = (state_q == StIdle);
    assign busy   = (state_q == StCalc) || (state_q == StDone);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign ALUsrc = 1'b0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized and directed bench for alu_muldiv_seq; includes a plain add/sub ALU
// and an arithmetic reference model for the expected results and latencies.
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opa, opb;
    logic         ready, busy, done;
    logic [W-1:0] result, ALUop1, ALUop2, ALUout;
    logic [2:0]   ALUctrl;
    logic         ALUsrc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared execute-stage ALU
    assign ALUout = (ALUctrl == 3'b001) ? ALUop1 - ALUop2 : ALUop1 + ALUop2;

    alu_muldiv_seq #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ALUop1 (ALUop1),
        .ALUop2 (ALUop2),
        .ALUctrl(ALUctrl),
        .ALUsrc (ALUsrc),
        .ALUout (ALUout)
    );

    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [W-1:0] r;
        case (o)
            2'd0:    r = a * b;
            2'd1:    r = (b == 0) ? '1 : a / b;
            2'd2:    r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] b);
        if (o == 2'd3 || (o != 2'd0 && b == 0)) return 1;
        return W + 1;
    endfunction

    // Drives one operation from IDLE; lat counts edges from the accept edge to done.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int lat, output int ctrl_bad);
        logic [2:0] exp_ctrl;
        exp_ctrl = (o == 2'd0) ? 3'b000 : 3'b001;
        ctrl_bad = 0;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && lat < W + 8) begin
            if (busy === 1'b1 && ALUctrl !== exp_ctrl) ctrl_bad++;
            if (ALUsrc !== 1'b0) ctrl_bad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (done === 1'b1 && (ALUop1 !== '0 || ALUop2 !== '0 || ALUctrl !== 3'b000)) ctrl_bad++;
        res = result;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ready, busy, done} !== 3'b100) $display("FAIL reset_flags: got %b want 100", {ready, busy, done});
        else n_pass++;
        n_checks++;
        if (result !== '0) $display("FAIL reset_result: got %h want 0", result);
        else n_pass++;
        n_checks++;
        if (ALUop1 !== '0 || ALUop2 !== '0 || ALUctrl !== 3'b000 || ALUsrc !== 1'b0)
            $display("FAIL reset_alu: got op1=%h op2=%h ctrl=%b src=%b want all 0",
                     ALUop1, ALUop2, ALUctrl, ALUsrc);
        else n_pass++;
    endtask

    typedef struct {logic [1:0] o; logic [W-1:0] a; logic [W-1:0] b;} vec_t;

    task automatic test_directed();
        vec_t v[12];
        logic [W-1:0] res, exp;
        int lat, bad;
        v[0]  = '{2'd0, 32'd7, 32'd6};
        v[1]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[2]  = '{2'd0, 32'h8000_0000, 32'd2};
        v[3]  = '{2'd1, 32'd100, 32'd7};
        v[4]  = '{2'd2, 32'd100, 32'd7};
        v[5]  = '{2'd1, 32'hFFFF_FFFF, 32'd1};
        v[6]  = '{2'd2, 32'hFFFF_FFFF, 32'd1};
        v[7]  = '{2'd1, 32'd5, 32'hFFFF_FFFF};
        v[8]  = '{2'd2, 32'd5, 32'hFFFF_FFFF};
        v[9]  = '{2'd1, 32'd123, 32'd0};
        v[10] = '{2'd2, 32'd123, 32'd0};
        v[11] = '{2'd3, 32'd55, 32'd9};
        for (int i = 0; i < 12; i++) begin
            do_op(v[i].o, v[i].a, v[i].b, res, lat, bad);
            exp = ref_result(v[i].o, v[i].a, v[i].b);
            n_checks++;
            if (res !== exp) $display("FAIL dir%0d_result: got %h want %h", i, res, exp);
            else n_pass++;
            n_checks++;
            if (lat !== ref_latency(v[i].o, v[i].b))
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, ref_latency(v[i].o, v[i].b));
            else n_pass++;
            n_checks++;
            if (bad !== 0) $display("FAIL dir%0d_alu_drive: got %0d bad cycles want 0", i, bad);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [1:0]   o;
        logic [W-1:0] a, b, res, exp;
        int lat, bad;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            do_op(o, a, b, res, lat, bad);
            exp = ref_result(o, a, b);
            n_checks++;
            if (res !== exp) $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got %h want %h", i, o, a, b, res, exp);
            else n_pass++;
            n_checks++;
            if (lat !== ref_latency(o, b))
                $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, ref_latency(o, b));
            else n_pass++;
            n_checks++;
            if (bad !== 0) $display("FAIL rnd%0d_alu_drive: got %0d bad cycles want 0", i, bad);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, exp1, exp2, res_at_done;
        int dones, done_cyc, lat;
        a1 = $urandom; b1 = $urandom_range(1, 1000);
        a2 = $urandom; b2 = $urandom_range(1, 1000);
        exp1 = ref_result(2'd1, a1, b1);
        exp2 = ref_result(2'd2, a2, b2);
        dones = 0; done_cyc = 0; res_at_done = '0;
        @(negedge clk);
        start = 1'b1; op = 2'd1; opa = a1; opb = b1;
        @(posedge clk);
        @(negedge clk);
        for (int cyc = 1; cyc <= W + 1; cyc++) begin
            if (done === 1'b1) begin
                dones++; done_cyc = cyc; res_at_done = result;
            end
            // Requests mid-calculation and in the done cycle must be dropped
            if (cyc == 5 || cyc == W + 1) begin
                start = 1'b1; op = 2'd0; opa = $urandom; opb = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 1 || done_cyc !== W + 1)
            $display("FAIL b2b_done_pulse: got %0d pulses at %0d want 1 at %0d", dones, done_cyc, W + 1);
        else n_pass++;
        n_checks++;
        if (res_at_done !== exp1) $display("FAIL b2b_first_result: got %h want %h", res_at_done, exp1);
        else n_pass++;
        n_checks++;
        if (result !== exp1 || ready !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_idle_hold: got result=%h ready=%b done=%b want %h 1 0",
                     result, ready, done, exp1);
        else n_pass++;
        start = 1'b1; op = 2'd2; opa = a2; opb = b2;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && lat < W + 8) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_checks++;
        if (lat !== W + 1) $display("FAIL b2b_second_latency: got %0d want %0d", lat, W + 1);
        else n_pass++;
        n_checks++;
        if (result !== exp2) $display("FAIL b2b_second_result: got %h want %h", result, exp2);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] res;
        int lat, bad, stray;
        do_op(2'd0, 32'd5, 32'd9, res, lat, bad);
        n_checks++;
        if (res !== 32'd45) $display("FAIL rst_pre_result: got %h want %h", res, 32'd45);
        else n_pass++;
        @(negedge clk);
        start = 1'b1; op = 2'd0; opa = $urandom | 32'h1; opb = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ready, busy, done} !== 3'b100)
            $display("FAIL rst_mid_flags: got %b want 100", {ready, busy, done});
        else n_pass++;
        n_checks++;
        if (result !== '0) $display("FAIL rst_mid_result: got %h want 0", result);
        else n_pass++;
        n_checks++;
        if (ALUop1 !== '0 || ALUop2 !== '0 || ALUctrl !== 3'b000)
            $display("FAIL rst_mid_alu: got op1=%h op2=%h ctrl=%b want 0", ALUop1, ALUop2, ALUctrl);
        else n_pass++;
        stray = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done === 1'b1 || busy === 1'b1) stray++;
            @(negedge clk);
        end
        n_checks++;
        if (stray !== 0) $display("FAIL rst_mid_quiet: got %0d active cycles want 0", stray);
        else n_pass++;
        do_op(2'd0, 32'd3, 32'd4, res, lat, bad);
        n_checks++;
        if (res !== 32'd12 || lat !== W + 1)
            $display("FAIL rst_post_mul: got %h lat %0d want %h lat %0d", res, lat, 32'd12, W + 1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
